// File: rtl/goal_sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous SRAM.
// Each command runs a fixed four-state sequence (IDLE, ACCESS, WAIT, DONE), so
// every transaction completes three cycles after its request is sampled.
// Addresses at or above DEPTH finish with an error flag and never reach the SRAM.
module goal_sram_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 34
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_byteen,
    output logic                  m0_done,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_byteen,
    output logic                  m1_done,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_err,

    output logic [ADDR_W-1:0]     sram_address,
    output logic                  sram_chipselect,
    output logic                  sram_write,
    output logic [DATA_W/8-1:0]   sram_byteenable,
    output logic [DATA_W-1:0]     sram_writedata,
    output logic                  sram_clken,
    input  logic [DATA_W-1:0]     sram_readdata,

    output logic                  busy
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // r_last_gnt = 1 means m1 held the most recent grant, so m0 wins the next tie.
    logic                r_last_gnt;
    logic                r_gnt;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_byteen;
    logic                r_oor;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_any_req;
    logic                w_gnt_sel;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [BE_W-1:0]     w_sel_byteen;
    logic                w_sram_sel;
    logic                w_capture;
    logic [DATA_W-1:0]   w_read_value;

    // Word address lies inside the populated part of the SRAM.
    function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < DEPTH);
    endfunction

    // Out-of-range reads return zero instead of whatever the SRAM bus carries.
    function automatic logic [DATA_W-1:0] f_read_value(input logic oor,
                                                       input logic [DATA_W-1:0] rd);
        return oor ? '0 : rd;
    endfunction

    // Round-robin pick between the two requesters and mux the winner's command.
    always_comb begin
        w_any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            w_gnt_sel = ~r_last_gnt;
        end else begin
            w_gnt_sel = m1_req;
        end
        if (w_gnt_sel) begin
            w_sel_write  = m1_write;
            w_sel_addr   = m1_addr;
            w_sel_wdata  = m1_wdata;
            w_sel_byteen = m1_byteen;
        end else begin
            w_sel_write  = m0_write;
            w_sel_addr   = m0_addr;
            w_sel_wdata  = m0_wdata;
            w_sel_byteen = m0_byteen;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; SRAM strobes are purely combinational so
    // an asynchronous reset drops them in the same cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_sram_sel      = 1'b0;
        sram_chipselect = 1'b0;
        sram_write      = 1'b0;
        m0_done         = 1'b0;
        m1_done         = 1'b0;
        m0_err          = 1'b0;
        m1_err          = 1'b0;
        busy            = 1'b1;
        w_capture       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_any_req) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_sram_sel      = ~r_oor;
                sram_chipselect = w_sram_sel;
                sram_write      = w_sram_sel & r_write;
                w_state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                w_capture   = ~r_write;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                m0_done     = ~r_gnt;
                m1_done     = r_gnt;
                m0_err      = ~r_gnt & r_oor;
                m1_err      = r_gnt & r_oor;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the granted command in IDLE; it stays fixed for the whole transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt <= 1'b1;
            r_gnt      <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_byteen   <= '0;
            r_oor      <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_gnt <= w_gnt_sel;
            r_gnt      <= w_gnt_sel;
            r_write    <= w_sel_write;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_byteen   <= w_sel_byteen;
            r_oor      <= ~f_in_range(w_sel_addr);
        end
    end

    assign w_read_value = f_read_value(r_oor, sram_readdata);

    // Capture read data for the granted requester as WAIT closes; writes leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_capture) begin
            if (r_gnt) begin
                r_rdata1 <= w_read_value;
            end else begin
                r_rdata0 <= w_read_value;
            end
        end
    end

    assign sram_address    = r_addr;
    assign sram_byteenable = r_byteen;
    assign sram_writedata  = r_wdata;
    assign sram_clken      = 1'b1;
    assign m0_rdata        = r_rdata0;
    assign m1_rdata        = r_rdata1;

endmodule

// File: tb/tb_goal_sram_arbiter.sv
// Bench for goal_sram_arbiter: directed vector table, multi-cycle corner
// sequences and a randomized two-requester run against a transaction-level model.
module tb_goal_sram_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 34;
    localparam int BE_W   = 2;
    localparam int MEM_N  = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic m0_req, m0_write, m1_req, m1_write;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [BE_W-1:0]   m0_byteen, m1_byteen;
    logic m0_done, m1_done, m0_err, m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] sram_address;
    logic sram_chipselect, sram_write, sram_clken, busy;
    logic [BE_W-1:0]   sram_byteenable;
    logic [DATA_W-1:0] sram_writedata;
    logic [DATA_W-1:0] sram_readdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    goal_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_byteen(m0_byteen), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_byteen(m1_byteen), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .sram_address(sram_address), .sram_chipselect(sram_chipselect),
        .sram_write(sram_write), .sram_byteenable(sram_byteenable),
        .sram_writedata(sram_writedata), .sram_clken(sram_clken),
        .sram_readdata(sram_readdata), .busy(busy)
    );

    // Synchronous SRAM: byte-masked write, read data one cycle after the address.
    logic [DATA_W-1:0] sram_mem [MEM_N] = '{default: '0};
    always @(posedge clk) begin
        if (sram_chipselect === 1'b1) begin
            if (sram_write === 1'b1) begin
                for (int b = 0; b < BE_W; b++)
                    if (sram_byteenable[b]) sram_mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
            end else begin
                sram_readdata <= sram_mem[sram_address];
            end
        end
    end

    // Count SRAM select cycles and remember the last address selected.
    int mon_cs_cnt = 0;
    logic [ADDR_W-1:0] mon_last_addr = '0;
    always @(negedge clk) begin
        if (sram_chipselect === 1'b1) begin
            mon_cs_cnt    <= mon_cs_cnt + 1;
            mon_last_addr <= sram_address;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic rq, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
        if (n == 0) begin
            m0_req = rq; m0_write = wr; m0_addr = a; m0_wdata = wd; m0_byteen = be;
        end else begin
            m1_req = rq; m1_write = wr; m1_addr = a; m1_wdata = wd; m1_byteen = be;
        end
    endtask

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] w,
                                                input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] r;
        r = o;
        for (int b = 0; b < BE_W; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    // One requester transaction from an idle arbiter; optionally changes the
    // address in the cycle after the grant.  Returns done latency in cycles.
    task automatic do_txn(input int n, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be,
                          input bit alt_en, input logic [ADDR_W-1:0] alt_a,
                          output logic [DATA_W-1:0] rd, output logic er, output int lat);
        bit got;
        got = 0; lat = -1; rd = '0; er = 1'b0;
        set_req(n, 1'b1, wr, a, wd, be);
        for (int c = 0; c < 10 && !got; c++) begin
            if (c == 1 && alt_en) set_req(n, 1'b1, wr, alt_a, wd, be);
            @(negedge clk);
            if ((n == 0) ? m0_done : m1_done) begin
                got = 1; lat = c;
                rd = (n == 0) ? m0_rdata : m1_rdata;
                er = (n == 0) ? m0_err : m1_err;
                chk("other_done_low", 32'((n == 0) ? m1_done : m0_done), 32'(0));
            end
            tick();
        end
        set_req(n, 1'b0, 1'b0, '0, '0, '0);
        if (!got) chk("txn_timeout", 32'(0), 32'(1));
    endtask

    typedef struct {
        int                n;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] exp_rd;
        logic              exp_err;
    } vec_t;

    vec_t tbl[11];

    // Random-phase state
    logic [DATA_W-1:0] model_mem [MEM_N];
    logic [DATA_W-1:0] mr [2];
    logic              rq [2];
    logic              rwr [2];
    logic [ADDR_W-1:0] ra [2];
    logic [DATA_W-1:0] rwd [2];
    logic [BE_W-1:0]   rbe [2];
    int                gap [2];

    initial begin
        logic [DATA_W-1:0] rd;
        logic er;
        int lat, prev_cs, ev;
        int free_c, gnt_c, done_c, who, n_txn;
        logic last, m_wr, m_oor, exp_acc, d0, d1;
        logic [ADDR_W-1:0] m_addr;
        logic [DATA_W-1:0] m_wd;
        logic [BE_W-1:0]   m_be;

        tbl[0]  = '{0, 1'b1, 6'd5,  16'hBEEF, 2'b11, 16'h0000, 1'b0};
        tbl[1]  = '{0, 1'b0, 6'd5,  16'h0000, 2'b11, 16'hBEEF, 1'b0};
        tbl[2]  = '{0, 1'b1, 6'd7,  16'h1234, 2'b11, 16'hBEEF, 1'b0};
        tbl[3]  = '{0, 1'b1, 6'd7,  16'hAB00, 2'b10, 16'hBEEF, 1'b0};
        tbl[4]  = '{0, 1'b0, 6'd7,  16'h0000, 2'b11, 16'hAB34, 1'b0};
        tbl[5]  = '{1, 1'b0, 6'd5,  16'h0000, 2'b11, 16'hBEEF, 1'b0};
        tbl[6]  = '{1, 1'b0, 6'd34, 16'h0000, 2'b11, 16'h0000, 1'b1};
        tbl[7]  = '{1, 1'b0, 6'd63, 16'h0000, 2'b11, 16'h0000, 1'b1};
        tbl[8]  = '{1, 1'b1, 6'd40, 16'hFFFF, 2'b11, 16'h0000, 1'b1};
        tbl[9]  = '{1, 1'b1, 6'd9,  16'h12CD, 2'b01, 16'h0000, 1'b0};
        tbl[10] = '{1, 1'b0, 6'd9,  16'h0000, 2'b11, 16'h00CD, 1'b0};

        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Values held while reset is asserted
        chk("rst_m0_done", 32'(m0_done), 32'(0));
        chk("rst_m1_done", 32'(m1_done), 32'(0));
        chk("rst_m0_err", 32'(m0_err), 32'(0));
        chk("rst_m1_err", 32'(m1_err), 32'(0));
        chk("rst_m0_rdata", 32'(m0_rdata), 32'(0));
        chk("rst_m1_rdata", 32'(m1_rdata), 32'(0));
        chk("rst_cs", 32'(sram_chipselect), 32'(0));
        chk("rst_write", 32'(sram_write), 32'(0));
        chk("rst_addr", 32'(sram_address), 32'(0));
        chk("rst_be", 32'(sram_byteenable), 32'(0));
        chk("rst_wdata", 32'(sram_writedata), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_clken", 32'(sram_clken), 32'(1));
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            prev_cs = mon_cs_cnt;
            do_txn(tbl[i].n, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, 1'b0, '0, rd, er, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(3));
            chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_cs_cycles", i), 32'(mon_cs_cnt - prev_cs), tbl[i].exp_err ? 32'(0) : 32'(1));
        end

        // Address changed the cycle after the grant must not reach the SRAM
        prev_cs = mon_cs_cnt;
        do_txn(0, 1'b1, 6'd2, 16'h7777, 2'b11, 1'b1, 6'd9, rd, er, lat);
        chk("latch_cs_cycles", 32'(mon_cs_cnt - prev_cs), 32'(1));
        chk("latch_sram_addr", 32'(mon_last_addr), 32'(2));
        do_txn(0, 1'b0, 6'd2, '0, 2'b11, 1'b0, '0, rd, er, lat);
        chk("latch_rd_addr2", 32'(rd), 32'h7777);
        do_txn(0, 1'b0, 6'd9, '0, 2'b11, 1'b0, '0, rd, er, lat);
        chk("latch_rd_addr9", 32'(rd), 32'h00CD);

        // Reset during ACCESS of a write aborts it
        do_txn(0, 1'b1, 6'd3, 16'h5555, 2'b11, 1'b0, '0, rd, er, lat);
        prev_cs = mon_cs_cnt;
        set_req(0, 1'b1, 1'b1, 6'd3, 16'hDEAD, 2'b11);
        @(negedge clk);
        tick();
        chk("abort_cs_in_access", 32'(sram_chipselect), 32'(1));
        #2 reset = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("abort_cs_dropped", 32'(sram_chipselect), 32'(0));
        chk("abort_write_dropped", 32'(sram_write), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_rdata_cleared", 32'(m0_rdata), 32'(0));
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({m0_done, m1_done}), 32'(0));
            tick();
        end
        chk("abort_cs_cycles", 32'(mon_cs_cnt - prev_cs), 32'(0));
        do_txn(0, 1'b0, 6'd3, '0, 2'b11, 1'b0, '0, rd, er, lat);
        chk("abort_prior_contents", 32'(rd), 32'h5555);

        // Both requesters held high from reset release: alternating grants
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 6'd5, '0, 2'b11);
        set_req(1, 1'b1, 1'b0, 6'd7, '0, 2'b11);
        tick();
        reset = 1'b0;
        ev = 0;
        for (int c = 0; c < 24 && ev < 4; c++) begin
            @(negedge clk);
            if (m0_done || m1_done) begin
                chk($sformatf("rr%0d_onehot", ev), 32'(m0_done ^ m1_done), 32'(1));
                chk($sformatf("rr%0d_who", ev), 32'(m1_done), 32'(ev % 2));
                chk($sformatf("rr%0d_cycle", ev), 32'(c), 32'(3 + 4 * ev));
                chk($sformatf("rr%0d_rdata", ev), m1_done ? 32'(m1_rdata) : 32'(m0_rdata),
                    m1_done ? 32'hAB34 : 32'hBEEF);
                ev++;
            end
            tick();
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        chk("rr_event_count", 32'(ev), 32'(4));

        // Randomized traffic against a transaction-level model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < MEM_N; i++) model_mem[i] = sram_mem[i];
        for (int n = 0; n < 2; n++) begin
            mr[n] = '0; rq[n] = 1'b0; rwr[n] = 1'b0; ra[n] = '0; rwd[n] = '0; rbe[n] = '0; gap[n] = 0;
        end
        free_c = 0; gnt_c = -10; done_c = -10; who = 0; last = 1'b1; n_txn = 0;
        m_wr = 1'b0; m_oor = 1'b0; m_addr = '0; m_wd = '0; m_be = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (rq[n] && done_c == c - 1 && who == n) begin
                    rq[n] = 1'b0;
                    gap[n] = int'($urandom_range(0, 2));
                end else if (!rq[n]) begin
                    if (gap[n] > 0) gap[n]--;
                    else if ($urandom_range(0, 1) == 1) begin
                        rq[n]  = 1'b1;
                        rwr[n] = 1'($urandom_range(0, 1));
                        ra[n]  = ($urandom_range(0, 3) == 0) ? 6'(34 + $urandom_range(0, 29))
                                                            : 6'($urandom_range(0, 33));
                        rwd[n] = 16'($urandom);
                        rbe[n] = 2'($urandom);
                    end
                end else if (who == n && c > gnt_c && c <= done_c) begin
                    rwr[n] = 1'($urandom_range(0, 1));
                    ra[n]  = 6'($urandom);
                    rwd[n] = 16'($urandom);
                    rbe[n] = 2'($urandom);
                end
                set_req(n, rq[n], rwr[n], ra[n], rwd[n], rbe[n]);
            end
            if (c == free_c) begin
                if (rq[0] || rq[1]) begin
                    if (rq[0] && rq[1]) who = last ? 0 : 1;
                    else who = rq[0] ? 0 : 1;
                    last   = (who == 1);
                    m_wr   = rwr[who];
                    m_addr = ra[who];
                    m_wd   = rwd[who];
                    m_be   = rbe[who];
                    m_oor  = (int'(m_addr) >= DEPTH);
                    gnt_c  = c;
                    done_c = c + 3;
                    free_c = c + 4;
                    n_txn++;
                end else begin
                    free_c = c + 1;
                end
            end
            @(negedge clk);
            exp_acc = (c == gnt_c + 1);
            chk("rnd_cs", 32'(sram_chipselect), 32'(exp_acc && !m_oor));
            chk("rnd_write", 32'(sram_write), 32'(exp_acc && !m_oor && m_wr));
            if (exp_acc && !m_oor) begin
                chk("rnd_addr", 32'(sram_address), 32'(m_addr));
                chk("rnd_be", 32'(sram_byteenable), 32'(m_be));
                chk("rnd_wdata", 32'(sram_writedata), 32'(m_wd));
            end
            chk("rnd_busy", 32'(busy), 32'(c > gnt_c && c <= gnt_c + 3));
            d0 = (c == done_c && who == 0);
            d1 = (c == done_c && who == 1);
            chk("rnd_m0_done", 32'(m0_done), 32'(d0));
            chk("rnd_m1_done", 32'(m1_done), 32'(d1));
            chk("rnd_m0_err", 32'(m0_err), 32'(d0 && m_oor));
            chk("rnd_m1_err", 32'(m1_err), 32'(d1 && m_oor));
            if (c == done_c) begin
                if (m_wr) begin
                    if (!m_oor) model_mem[m_addr] = merge(model_mem[m_addr], m_wd, m_be);
                end else begin
                    mr[who] = m_oor ? '0 : model_mem[m_addr];
                end
                chk("rnd_rdata", (who == 0) ? 32'(m0_rdata) : 32'(m1_rdata), 32'(mr[who]));
            end
            tick();
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        chk("rnd_txn_count_enough", 32'(n_txn > 300), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/goal_sram_arbiter.md
GOAL_SRAM_ARBITER -- requirements
Module: goal_sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning the word address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the data width; the byte-enable width is DATA_W/8.
REQ-003 The block SHALL have parameter DEPTH, default 34, meaning the number of valid SRAM words.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mN_req  in  1  request from requester N (N=0,1); held high until mN_done.
- mN_write  in  1  1 = write, 0 = read.
- mN_addr  in  ADDR_W  word address.
- mN_wdata  in  DATA_W  write data.
- mN_byteen  in  DATA_W/8  byte enables.
- mN_done  out  1  one-cycle completion pulse.
- mN_rdata  out  DATA_W  read result; valid while mN_done is high.
- mN_err  out  1  out-of-range flag; valid while mN_done is high.
- sram_address  out  ADDR_W  SRAM port address.
- sram_chipselect  out  1  SRAM port select.
- sram_write  out  1  SRAM port write.
- sram_byteenable  out  DATA_W/8  SRAM port byte enables.
- sram_writedata  out  DATA_W  SRAM port write data.
- sram_clken  out  1  SRAM port clock enable; constant 1.
- sram_readdata  in  DATA_W  SRAM read data, valid one cycle after the address cycle.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 The FSM SHALL have four states: IDLE, ACCESS, WAIT and DONE; the sequence is IDLE->ACCESS->WAIT->DONE->IDLE.
REQ-006 In IDLE, when at least one mN_req is high, the block SHALL grant one requester, latch its write/addr/wdata/byteen, and move to ACCESS on the next edge.
REQ-007 Arbitration SHALL be round-robin: when both requests are high, grant the requester not granted last; a single request is granted directly.
REQ-008 The last-grant record SHALL be 1 after reset, so m0 wins the first contention.
REQ-009 In ACCESS, for an in-range command (addr < DEPTH), the block SHALL drive sram_chipselect=1, sram_write=latched write, and the latched address, byteenable and writedata.
REQ-010 In every other state, and for out-of-range commands, sram_chipselect and sram_write SHALL be 0.
REQ-011 sram_chipselect and sram_write SHALL be decoded combinationally from the state and the latched command, so an asynchronous reset removes them immediately.
REQ-012 In WAIT, the block SHALL capture sram_readdata into the granted requester's rdata register on the closing edge for in-range reads.
REQ-013 For out-of-range reads, the captured value SHALL be 0.
REQ-014 For writes, the block SHALL leave mN_rdata unchanged.
REQ-015 In DONE, the block SHALL assert mN_done=1 for the granted requester only, for exactly one cycle.
REQ-016 In DONE, mN_err SHALL be 1 for out-of-range commands and 0 otherwise; mN_err is 0 whenever mN_done is 0.
REQ-017 Requests SHALL NOT be sampled in ACCESS, WAIT or DONE; a requester drops mN_req in the cycle after mN_done, and a req still high in IDLE is a new command.
REQ-018 Fixed latency SHALL be 3 cycles: req sampled in IDLE at cycle t; ACCESS at t+1; WAIT at t+2; mN_done at t+3; next grant is possible at t+4.
REQ-019 The out-of-range path SHALL take the same 4-state sequence and timing as an in-range access.
REQ-020 The latched command SHALL be used throughout a transaction; requester input changes after the grant SHALL have no effect.
REQ-021 The block SHALL sustain one transaction per 4 cycles under continuous load, with alternating grants when both requesters are active.

Reset
REQ-022 While reset is high, the block SHALL hold: state=IDLE; last-grant=1; all mN_done=0, mN_err=0, mN_rdata=0; sram_chipselect=0, sram_write=0, sram_address=0, sram_byteenable=0, sram_writedata=0; busy=0; sram_clken=1.
REQ-023 Reset asserted mid-transaction SHALL abort it with no mN_done pulse and no further SRAM write.
REQ-024 After reset, a request still held high SHALL be re-arbitrated from IDLE.

Verification
REQ-025 m0 write addr=5, wdata=0xBEEF, byteen=2'b11; then m0 read addr=5 -> second mN_done 3 cycles after the second req, m0_rdata=0xBEEF, m0_err=0.
REQ-026 Write 0x1234 to addr=7, then write 0xAB00 with byteen=2'b10; read addr=7 -> m0_rdata=0xAB34.
REQ-027 m0_req and m1_req both held high from reset release for 4 transactions -> grants m0, m1, m0, m1, with each mN_done exactly 4 cycles apart.
REQ-028 m1 read addr=34 and addr=63 -> sram_chipselect never high, m1_err=1, m1_rdata=0, mN_done timing identical to an in-range read.
REQ-029 Assert reset during ACCESS of a write to addr=3 -> sram_chipselect drops in the same cycle, no mN_done pulse, and a later read of addr=3 returns its prior contents.
REQ-030 m0 changes addr from 2 to 9 in the cycle after the grant -> the SRAM is accessed at addr=2 only.
